// File: rtl/riscv_commit_checker_if.sv
// Bundle for the commit checker: table programming, core observation and status.
// The checker is the slave; the bench or bring-up logic driving it is the master.
interface riscv_commit_checker_if #(
  parameter int IDX_W  = 5,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 32
);
  logic              CFG_WE;
  logic [IDX_W-1:0]  CFG_IDX;
  logic [DWIDTH-1:0] CFG_NUM_INST;
  logic [DWIDTH-1:0] CFG_ANS;
  logic [IDX_W-1:0]  TEST_LEN;
  logic              START;
  logic [DWIDTH-1:0] NUM_INST;
  logic [DWIDTH-1:0] OUTPUT_PORT;
  logic              HALT;
  logic [1:0]        RESULT;
  logic              DONE;
  logic [IDX_W-1:0]  PASS_CNT;
  logic [IDX_W-1:0]  FAIL_CNT;
  logic [IDX_W-1:0]  FAIL_IDX;
  logic [DWIDTH-1:0] FAIL_VAL;
  logic              FAIL_MISS;
  logic [CWIDTH-1:0] CYCLE;

  modport master (
    output CFG_WE, CFG_IDX, CFG_NUM_INST, CFG_ANS, TEST_LEN, START,
           NUM_INST, OUTPUT_PORT, HALT,
    input  RESULT, DONE, PASS_CNT, FAIL_CNT, FAIL_IDX, FAIL_VAL, FAIL_MISS, CYCLE
  );

  modport slave (
    input  CFG_WE, CFG_IDX, CFG_NUM_INST, CFG_ANS, TEST_LEN, START,
           NUM_INST, OUTPUT_PORT, HALT,
    output RESULT, DONE, PASS_CNT, FAIL_CNT, FAIL_IDX, FAIL_VAL, FAIL_MISS, CYCLE
  );
endinterface

// File: rtl/riscv_commit_checker.sv
// Commit self-check monitor: walks a table of (instruction count, expected output)
// checkpoints against the core, with a RUN-cycle watchdog and status outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset; table writable, waiting for START
// S_RUN    | comparing NUM_INST/OUTPUT_PORT against entry[ptr]
// S_D_PASS | HALT seen with every checkpoint passed (RESULT=1)
// S_D_FAIL | mismatch/miss (RESULT=2); START re-runs with the same table
// S_D_TOUT | watchdog expired (RESULT=3)
module riscv_commit_checker #(
  parameter int NUM_TEST     = 17,
  parameter int IDX_W        = 5,
  parameter int DWIDTH       = 32,
  parameter int CWIDTH       = 32,
  parameter int TIMEOUT      = 1000000,
  parameter int STOP_ON_FAIL = 1
) (
  input logic                  CLK,
  input logic                  RSTn,
  riscv_commit_checker_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_D_PASS,
    S_D_FAIL,
    S_D_TOUT
  } state_t;

  localparam logic [IDX_W-1:0]  NUM_TEST_W = IDX_W'(NUM_TEST);
  localparam logic [CWIDTH-1:0] TOUT_LAST  = (TIMEOUT == 0) ? '0 : CWIDTH'(TIMEOUT - 1);
  localparam bit                WDOG_EN    = (TIMEOUT != 0);
  localparam bit                STOP_EN    = (STOP_ON_FAIL != 0);

  state_t            state_q;
  logic [DWIDTH-1:0] tbl_num [NUM_TEST];
  logic [DWIDTH-1:0] tbl_ans [NUM_TEST];
  logic [IDX_W-1:0]  len_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  pass_q;
  logic [IDX_W-1:0]  fail_q;
  logic [IDX_W-1:0]  fidx_q;
  logic [DWIDTH-1:0] fval_q;
  logic              fmiss_q;
  logic [CWIDTH-1:0] cyc_q;
  logic [1:0]        result_q;
  logic              done_q;

  logic              active;
  logic [IDX_W-1:0]  rd_idx;
  logic [DWIDTH-1:0] cur_num;
  logic [DWIDTH-1:0] cur_ans;
  logic              hit;
  logic              miss;
  logic              good;
  logic              bad;
  logic [IDX_W-1:0]  ptr_nx;
  logic [IDX_W-1:0]  pass_nx;
  logic [IDX_W-1:0]  fail_nx;
  logic [CWIDTH-1:0] cyc_inc;
  logic              wdog;
  logic [IDX_W-1:0]  len_start;

  always_comb begin
    active    = (ptr_q < len_q);
    rd_idx    = active ? ptr_q : '0;
    cur_num   = tbl_num[rd_idx];
    cur_ans   = tbl_ans[rd_idx];
    hit       = active && (bus.NUM_INST == cur_num);
    miss      = active && (bus.NUM_INST > cur_num);
    good      = hit && (bus.OUTPUT_PORT == cur_ans);
    bad       = miss || (hit && !good);
    ptr_nx    = (hit || miss) ? ptr_q + IDX_W'(1) : ptr_q;
    pass_nx   = good ? pass_q + IDX_W'(1) : pass_q;
    fail_nx   = bad ? fail_q + IDX_W'(1) : fail_q;
    cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + CWIDTH'(1);
    wdog      = WDOG_EN && (cyc_q == TOUT_LAST);
    len_start = (bus.TEST_LEN > NUM_TEST_W) ? NUM_TEST_W : bus.TEST_LEN;
  end

  // Table is only writable in IDLE so a running check never sees it change.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        tbl_num[i] <= '0;
        tbl_ans[i] <= '0;
      end
    end else if (state_q == S_IDLE && bus.CFG_WE && bus.CFG_IDX < NUM_TEST_W) begin
      tbl_num[bus.CFG_IDX] <= bus.CFG_NUM_INST;
      tbl_ans[bus.CFG_IDX] <= bus.CFG_ANS;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      ptr_q    <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      fidx_q   <= '0;
      fval_q   <= '0;
      fmiss_q  <= 1'b0;
      cyc_q    <= '0;
      result_q <= 2'd0;
      done_q   <= 1'b0;
    end else if (state_q != S_RUN) begin
      if (bus.START) begin
        state_q  <= S_RUN;
        len_q    <= len_start;
        ptr_q    <= '0;
        pass_q   <= '0;
        fail_q   <= '0;
        fidx_q   <= '0;
        fval_q   <= '0;
        fmiss_q  <= 1'b0;
        cyc_q    <= '0;
        result_q <= 2'd0;
        done_q   <= 1'b0;
      end
    end else begin
      ptr_q  <= ptr_nx;
      pass_q <= pass_nx;
      fail_q <= fail_nx;
      if (bad && fail_q == '0) begin
        fidx_q  <= ptr_q;
        fval_q  <= bus.OUTPUT_PORT;
        fmiss_q <= miss;
      end
      if (bad && STOP_EN) begin
        state_q  <= S_D_FAIL;
        result_q <= 2'd2;
        done_q   <= 1'b1;
        cyc_q    <= cyc_inc;
      end else if (bus.HALT) begin
        done_q <= 1'b1;
        cyc_q  <= cyc_inc;
        if (ptr_nx == len_q && fail_nx == '0) begin
          state_q  <= S_D_PASS;
          result_q <= 2'd1;
        end else begin
          state_q  <= S_D_FAIL;
          result_q <= 2'd2;
          // Halting early with nothing failed yet: blame the first unreached entry.
          if (fail_nx == '0) begin
            fidx_q  <= ptr_nx;
            fval_q  <= bus.OUTPUT_PORT;
            fmiss_q <= 1'b1;
          end
        end
      end else if (wdog) begin
        // CYCLE is held at TIMEOUT-1 so it reads back the cycle that expired.
        state_q  <= S_D_TOUT;
        result_q <= 2'd3;
        done_q   <= 1'b1;
      end else begin
        cyc_q <= cyc_inc;
      end
    end
  end

  assign bus.RESULT    = result_q;
  assign bus.DONE      = done_q;
  assign bus.PASS_CNT  = pass_q;
  assign bus.FAIL_CNT  = fail_q;
  assign bus.FAIL_IDX  = fidx_q;
  assign bus.FAIL_VAL  = fval_q;
  assign bus.FAIL_MISS = fmiss_q;
  assign bus.CYCLE     = cyc_q;

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Bench for riscv_commit_checker: two instances (stop-on-fail with a 20-cycle
// watchdog, and keep-going without one) driven by the same vectors and random runs.
module tb_riscv_commit_checker;

  typedef struct packed {
    logic [1:0]  res;
    logic        done;
    logic [4:0]  pass;
    logic [4:0]  fail;
    logic [4:0]  fidx;
    logic [31:0] fval;
    logic        fmiss;
    logic [31:0] cyc;
  } outs_t;

  typedef struct {
    bit          rst;
    bit          we;
    int          idx;
    logic [31:0] cnum;
    logic [31:0] cans;
    int          tlen;
    bit          st;
    logic [31:0] ni;
    logic [31:0] op;
    bit          ht;
    bit          chk;
    int          who;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_commit_checker_if #(.IDX_W(5), .DWIDTH(32), .CWIDTH(32)) ia ();
  riscv_commit_checker_if #(.IDX_W(5), .DWIDTH(32), .CWIDTH(32)) ib ();

  riscv_commit_checker #(.NUM_TEST(17), .IDX_W(5), .DWIDTH(32), .CWIDTH(32),
                         .TIMEOUT(20), .STOP_ON_FAIL(1))
    dut_a (.CLK(clk), .RSTn(rst_n), .bus(ia.slave));
  riscv_commit_checker #(.NUM_TEST(17), .IDX_W(5), .DWIDTH(32), .CWIDTH(32),
                         .TIMEOUT(0), .STOP_ON_FAIL(0))
    dut_b (.CLK(clk), .RSTn(rst_n), .bus(ib.slave));

  assign ib.CFG_WE       = ia.CFG_WE;
  assign ib.CFG_IDX      = ia.CFG_IDX;
  assign ib.CFG_NUM_INST = ia.CFG_NUM_INST;
  assign ib.CFG_ANS      = ia.CFG_ANS;
  assign ib.TEST_LEN     = ia.TEST_LEN;
  assign ib.START        = ia.START;
  assign ib.NUM_INST     = ia.NUM_INST;
  assign ib.OUTPUT_PORT  = ia.OUTPUT_PORT;
  assign ib.HALT         = ia.HALT;

  outs_t got_a, got_b;
  assign got_a = {ia.RESULT, ia.DONE, ia.PASS_CNT, ia.FAIL_CNT, ia.FAIL_IDX,
                  ia.FAIL_VAL, ia.FAIL_MISS, ia.CYCLE};
  assign got_b = {ib.RESULT, ib.DONE, ib.PASS_CNT, ib.FAIL_CNT, ib.FAIL_IDX,
                  ib.FAIL_VAL, ib.FAIL_MISS, ib.CYCLE};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per instance, the checkpoint list plus a cursor to the oldest pending one.
  int          m_phase [2];  // 0 idle, 1 run, 2 done
  int          m_len [2];
  int          m_next [2];
  int          m_pass [2];
  int          m_fail [2];
  int          m_fidx [2];
  int          m_fmiss [2];
  int          m_res [2];
  int          m_done [2];
  logic [31:0] m_fval [2];
  logic [31:0] m_cyc [2];
  logic [31:0] mt_num [2][17];
  logic [31:0] mt_ans [2][17];

  function automatic bit stop_of(int c);
    return c == 0;
  endfunction

  function automatic int tout_of(int c);
    return (c == 0) ? 20 : 0;
  endfunction

  task automatic model_end(int c, int r);
    m_phase[c] = 2;
    m_res[c]   = r;
    m_done[c]  = 1;
  endtask

  task automatic model_step(int c, vec_t v);
    int k;
    bit ret, bad, miss, wd;
    if (!v.rst) begin
      m_phase[c] = 0; m_len[c] = 0; m_next[c] = 0; m_pass[c] = 0; m_fail[c] = 0;
      m_fidx[c] = 0; m_fmiss[c] = 0; m_res[c] = 0; m_done[c] = 0;
      m_fval[c] = '0; m_cyc[c] = '0;
      for (int i = 0; i < 17; i++) begin
        mt_num[c][i] = '0;
        mt_ans[c][i] = '0;
      end
    end else if (m_phase[c] != 1) begin
      if (m_phase[c] == 0 && v.we && v.idx < 17) begin
        mt_num[c][v.idx] = v.cnum;
        mt_ans[c][v.idx] = v.cans;
      end
      if (v.st) begin
        m_phase[c] = 1; m_len[c] = (v.tlen > 17) ? 17 : v.tlen;
        m_next[c] = 0; m_pass[c] = 0; m_fail[c] = 0; m_fidx[c] = 0; m_fmiss[c] = 0;
        m_res[c] = 0; m_done[c] = 0; m_fval[c] = '0; m_cyc[c] = '0;
      end
    end else begin
      k = m_next[c]; ret = 0; bad = 0; miss = 0; wd = 0;
      if (k < m_len[c]) begin
        if (v.ni == mt_num[c][k]) begin
          ret = 1; bad = (v.op != mt_ans[c][k]);
        end else if (v.ni > mt_num[c][k]) begin
          ret = 1; bad = 1; miss = 1;
        end
      end
      if (ret) m_next[c]++;
      if (bad) begin
        if (m_fail[c] == 0) begin
          m_fidx[c] = k; m_fval[c] = v.op; m_fmiss[c] = miss;
        end
        m_fail[c]++;
      end else if (ret) begin
        m_pass[c]++;
      end
      if (bad && stop_of(c)) begin
        model_end(c, 2);
      end else if (v.ht) begin
        if (m_next[c] == m_len[c] && m_fail[c] == 0) model_end(c, 1);
        else begin
          if (m_fail[c] == 0) begin
            m_fidx[c] = m_next[c]; m_fval[c] = v.op; m_fmiss[c] = 1;
          end
          model_end(c, 2);
        end
      end else if (tout_of(c) != 0 && m_cyc[c] == 32'(tout_of(c) - 1)) begin
        wd = 1;
        model_end(c, 3);
      end
      if (!wd) m_cyc[c] = m_cyc[c] + 1;
    end
  endtask

  function automatic outs_t model_out(int c);
    outs_t o;
    o.res   = 2'(m_res[c]);
    o.done  = (m_done[c] != 0);
    o.pass  = 5'(m_pass[c]);
    o.fail  = 5'(m_fail[c]);
    o.fidx  = 5'(m_fidx[c]);
    o.fval  = m_fval[c];
    o.fmiss = (m_fmiss[c] != 0);
    o.cyc   = m_cyc[c];
    return o;
  endfunction

  task automatic cmp(string name, outs_t got, outs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got res=%0d done=%0d pass=%0d fail=%0d idx=%0d val=%h miss=%0d cyc=%0d | expected res=%0d done=%0d pass=%0d fail=%0d idx=%0d val=%h miss=%0d cyc=%0d",
               name, got.res, got.done, got.pass, got.fail, got.fidx, got.fval, got.fmiss, got.cyc,
               exp.res, exp.done, exp.pass, exp.fail, exp.fidx, exp.fval, exp.fmiss, exp.cyc);
    end
  endtask

  task automatic apply(vec_t v, string name);
    rst_n           = v.rst;
    ia.CFG_WE       = v.we;
    ia.CFG_IDX      = 5'(v.idx);
    ia.CFG_NUM_INST = v.cnum;
    ia.CFG_ANS      = v.cans;
    ia.TEST_LEN     = 5'(v.tlen);
    ia.START        = v.st;
    ia.NUM_INST     = v.ni;
    ia.OUTPUT_PORT  = v.op;
    ia.HALT         = v.ht;
    @(posedge clk);
    #1;
    model_step(0, v);
    model_step(1, v);
    cmp({name, "_model_a"}, got_a, model_out(0));
    cmp({name, "_model_b"}, got_b, model_out(1));
    if (v.chk) cmp({name, "_vector"}, (v.who == 0) ? got_a : got_b, v.exp);
  endtask

  vec_t vq[$];

  function automatic void add(bit rst, bit we, int idx, logic [31:0] cnum, logic [31:0] cans,
                              int tlen, bit st, logic [31:0] ni, logic [31:0] op, bit ht);
    vec_t v;
    v.rst = rst; v.we = we; v.idx = idx; v.cnum = cnum; v.cans = cans; v.tlen = tlen;
    v.st = st; v.ni = ni; v.op = op; v.ht = ht; v.chk = 0; v.who = 0; v.exp = '0;
    vq.push_back(v);
  endfunction

  function automatic void expect_last(int who, int res, int done, int pass, int fail, int fidx,
                                      logic [31:0] fval, int fmiss, int cyc);
    vec_t v;
    v = vq.pop_back();
    v.chk = 1; v.who = who;
    v.exp.res = 2'(res); v.exp.done = done[0]; v.exp.pass = 5'(pass); v.exp.fail = 5'(fail);
    v.exp.fidx = 5'(fidx); v.exp.fval = fval; v.exp.fmiss = fmiss[0]; v.exp.cyc = 32'(cyc);
    vq.push_back(v);
  endfunction

  function automatic logic [31:0] opfor(int n);
    case (n)
      4:       return 32'h0eec;
      6:       return 32'h0000;
      8:       return 32'h0001;
      default: return 32'h0000;
    endcase
  endfunction

  function automatic void run_rows(int lo, int hi);
    for (int n = lo; n <= hi; n++) add(1, 0, 0, 0, 0, 3, 0, n, opfor(n), 0);
  endfunction

  function automatic void start_row(int tlen);
    add(1, 0, 0, 0, 0, tlen, 1, 0, 0, 0);
  endfunction

  initial begin
    logic [31:0] tnum [17];
    logic [31:0] tans [17];
    logic [31:0] num, ni;
    vec_t v;

    ia.CFG_WE = 0; ia.CFG_IDX = '0; ia.CFG_NUM_INST = '0; ia.CFG_ANS = '0;
    ia.TEST_LEN = '0; ia.START = 0; ia.NUM_INST = '0; ia.OUTPUT_PORT = '0; ia.HALT = 0;

    // reset and program {4:0x0eec, 6:0x0000, 8:0x0001}; index 17 is out of range
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);           expect_last(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4, 32'h0eec, 0, 0, 0, 0, 0);
    add(1, 1, 1, 6, 32'h0000, 0, 0, 0, 0, 0);
    add(1, 1, 2, 8, 32'h0001, 0, 0, 0, 0, 0);
    add(1, 1, 17, 0, 32'hdead, 0, 0, 0, 0, 0);
    // all match, then HALT
    start_row(3);                                expect_last(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_rows(0, 8);
    add(1, 0, 0, 0, 0, 3, 0, 8, 1, 1);           expect_last(0, 1, 1, 3, 0, 0, 0, 0, 10);
    // wrong value at entry 1
    start_row(3);
    run_rows(0, 5);
    add(1, 0, 0, 0, 0, 3, 0, 6, 5, 0);           expect_last(0, 2, 1, 1, 1, 1, 5, 0, 7);
    add(1, 0, 0, 0, 0, 3, 0, 7, 0, 0);
    add(1, 0, 0, 0, 0, 3, 0, 8, 1, 0);
    add(1, 0, 0, 0, 0, 3, 0, 8, 1, 1);           expect_last(1, 2, 1, 2, 1, 1, 5, 0, 10);
    // NUM_INST skips 6
    start_row(3);
    run_rows(0, 5);
    add(1, 0, 0, 0, 0, 3, 0, 7, 32'h33, 0);      expect_last(0, 2, 1, 1, 1, 1, 32'h33, 1, 7);
    add(1, 0, 0, 0, 0, 3, 0, 8, 1, 0);
    add(1, 0, 0, 0, 0, 3, 0, 8, 1, 1);           expect_last(1, 2, 1, 2, 1, 1, 32'h33, 1, 9);
    // HALT with entry 1 still pending
    start_row(3);
    run_rows(0, 4);
    add(1, 0, 0, 0, 0, 3, 0, 5, 32'h44, 1);      expect_last(0, 2, 1, 1, 0, 1, 32'h44, 1, 6);
    // HALT together with the final match
    start_row(3);
    run_rows(0, 7);
    add(1, 0, 0, 0, 0, 3, 0, 8, 1, 1);           expect_last(0, 1, 1, 3, 0, 0, 0, 0, 9);
    // watchdog with NUM_INST frozen, then re-run on the kept table
    start_row(3);
    for (int k = 1; k <= 19; k++) add(1, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    expect_last(0, 0, 0, 0, 0, 0, 0, 0, 19);
    add(1, 0, 0, 0, 0, 3, 0, 0, 0, 0);           expect_last(0, 3, 1, 0, 0, 0, 0, 0, 19);
    start_row(3);                                expect_last(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_rows(0, 8);
    add(1, 0, 0, 0, 0, 3, 0, 8, 1, 1);           expect_last(0, 1, 1, 3, 0, 0, 0, 0, 10);
    // empty table
    start_row(0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);           expect_last(0, 1, 1, 0, 0, 0, 0, 0, 1);
    // reset mid-run, then a write during RUN is ignored
    start_row(1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);           expect_last(0, 0, 0, 0, 0, 0, 0, 0, 0);
    start_row(1);
    add(1, 1, 0, 5, 32'h77, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);           expect_last(0, 1, 1, 1, 0, 0, 0, 0, 2);

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // randomized runs against the model
    for (int r = 0; r < 30; r++) begin
      v.rst = 0; v.we = 0; v.idx = 0; v.cnum = '0; v.cans = '0; v.tlen = 0;
      v.st = 0; v.ni = '0; v.op = '0; v.ht = 0; v.chk = 0; v.who = 0; v.exp = '0;
      apply(v, $sformatf("rnd%0d_rst", r));
      v.rst = 1;
      num = 32'($urandom_range(0, 2));
      for (int i = 0; i < 17; i++) begin
        tnum[i] = num;
        tans[i] = 32'($urandom_range(0, 3));
        num = num + 32'($urandom_range(0, 2));
        v.we = 1; v.idx = i; v.cnum = tnum[i]; v.cans = tans[i];
        apply(v, $sformatf("rnd%0d_cfg", r));
      end
      v.we = 0; v.st = 1; v.tlen = int'($urandom_range(0, 31));
      apply(v, $sformatf("rnd%0d_start", r));
      ni = '0;
      for (int k = 0; k < 45; k++) begin
        ni = ni + (($urandom_range(0, 9) == 0) ? 32'd3 : 32'($urandom_range(0, 1)));
        v.ni = ni;
        v.op = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) < 7)
          for (int j = 16; j >= 0; j--) if (tnum[j] == ni) v.op = tans[j];
        v.ht   = (k == 44) || ($urandom_range(0, 39) == 0);
        v.st   = ($urandom_range(0, 9) == 0);
        v.tlen = int'($urandom_range(0, 31));
        v.we   = ($urandom_range(0, 7) == 0);
        v.idx  = int'($urandom_range(0, 20));
        v.cnum = 32'($urandom);
        v.cans = 32'($urandom);
        apply(v, $sformatf("rnd%0d_c%0d", r, k));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_commit_checker.md
Name: riscv_commit_checker

Overview:
- Synthesizable, parametrised self-check monitor for RISCV_TOP simulations and FPGA bring-up.
- Holds a programmable table of (instruction count, expected OUTPUT_PORT) checkpoints.
- Compares the core's NUM_INST/OUTPUT_PORT against the table in order, detects skipped checkpoints, and applies a cycle watchdog.
- Reports pass/fail/timeout through status ports instead of $display/$finish.

Parameters:
- NUM_TEST, 17, table depth.
- IDX_W, 5, index width; must be at least clog2(NUM_TEST+1).
- DWIDTH, 32, width of NUM_INST, OUTPUT_PORT and expected answers.
- CWIDTH, 32, cycle counter width.
- TIMEOUT, 1000000, watchdog limit in RUN cycles; 0 disables the watchdog.
- STOP_ON_FAIL, 1, 1 = end on the first failure; 0 = keep checking and count failures.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- CFG_WE  in  1  table write strobe; honoured only in IDLE.
- CFG_IDX  in  IDX_W  table entry index.
- CFG_NUM_INST  in  DWIDTH  checkpoint instruction count.
- CFG_ANS  in  DWIDTH  expected OUTPUT_PORT value.
- TEST_LEN  in  IDX_W  number of active entries; sampled on START.
- START  in  1  begin a run from IDLE or any DONE state.
- NUM_INST  in  DWIDTH  retired-instruction count from the core.
- OUTPUT_PORT  in  DWIDTH  core output port.
- HALT  in  1  core halt.
- RESULT  out  2  0 = idle/running, 1 = pass, 2 = fail, 3 = timeout.
- DONE  out  1  high in any DONE state.
- PASS_CNT  out  IDX_W  checkpoints passed.
- FAIL_CNT  out  IDX_W  checkpoints failed or missed.
- FAIL_IDX  out  IDX_W  index of the first failing entry.
- FAIL_VAL  out  DWIDTH  OUTPUT_PORT value at the first failure.
- FAIL_MISS  out  1  first failure was a skipped checkpoint, not a value mismatch.
- CYCLE  out  CWIDTH  RUN cycles elapsed; saturates.

Behaviour:
- Reset (asynchronous, RSTn=0):
  - State goes to IDLE.
  - All outputs are 0.
  - Table entries, the length register and the pointer are cleared.
  - A reset mid-run aborts with no result held.
- States: IDLE, RUN, D_PASS, D_FAIL, D_TOUT.
  - DONE = 1 and RESULT is held in all three D_* states.
- IDLE: CFG_WE writes entry[CFG_IDX] on the clock edge. CFG_IDX >= NUM_TEST is ignored. CFG_WE is ignored in every other state.
- START, from IDLE or any D_* state:
  - Next cycle the state is RUN.
  - LEN <= min(TEST_LEN, NUM_TEST).
  - PTR, PASS_CNT, FAIL_CNT, CYCLE, FAIL_* are all cleared.
  - RESULT <= 0.
  - The table is retained, so a re-run reuses it.
  - START while in RUN is ignored.
- RUN, every clock: CYCLE increments, saturating at all-ones. Only entry[PTR] is evaluated, and only while PTR < LEN.
  - Match (NUM_INST == entry.num): if OUTPUT_PORT == entry.ans, then PASS_CNT++; otherwise FAIL_CNT++. PTR++ in both cases.
  - Miss (NUM_INST > entry.num, unsigned): FAIL_CNT++, PTR++, miss flag set.
  - NUM_INST < entry.num: no action.
  - At most one entry retires per cycle. Duplicate counts retire on consecutive cycles while NUM_INST holds.
  - The bench must program entries with non-decreasing num.
- First failure: FAIL_IDX <= PTR, FAIL_VAL <= OUTPUT_PORT, FAIL_MISS <= miss. These registers are written once per run.
  - If STOP_ON_FAIL = 1, the next state is D_FAIL immediately.
- HALT in RUN:
  - Evaluated after the same-cycle checkpoint update.
  - Go to D_PASS if all LEN entries are done and FAIL_CNT (updated) = 0.
  - Otherwise go to D_FAIL.
  - If no failure was recorded yet, FAIL_IDX <= updated PTR, FAIL_MISS <= 1, FAIL_VAL <= OUTPUT_PORT.
- Without HALT, RUN continues after all entries are done; only HALT or the watchdog ends the run.
- Watchdog: if TIMEOUT != 0 and CYCLE == TIMEOUT-1 in RUN with no HALT or stopping failure that cycle, go to D_TOUT.
- Priority within a RUN cycle: checkpoint update, then fail-stop, then HALT, then watchdog.
- LEN = 0 with HALT gives D_PASS.
- Counters cannot overflow because they are bounded by LEN.

Test Plan:
- Program entries {4:0x0eec, 6:0x0000, 8:0x0001}, LEN=3, START. Drive NUM_INST 0..8 with matching OUTPUT_PORT, then HALT -> RESULT=1, DONE=1, PASS_CNT=3, FAIL_CNT=0.
- Same table, OUTPUT_PORT=0x0005 at NUM_INST=6, STOP_ON_FAIL=1 -> D_FAIL on the next edge, FAIL_IDX=1, FAIL_VAL=0x5, FAIL_MISS=0, PASS_CNT=1.
- NUM_INST jumps 5 -> 7 with entry 6 pending -> FAIL_MISS=1, FAIL_IDX=1. Repeat with STOP_ON_FAIL=0 and the run completed -> HALT gives RESULT=2, PASS_CNT=2, FAIL_CNT=1.
- HALT asserted when PTR=1 of LEN=3 -> RESULT=2, FAIL_IDX=1, FAIL_MISS=1. HALT in the same cycle as the final correct match -> RESULT=1.
- TIMEOUT=20, NUM_INST frozen at 0 -> D_TOUT with CYCLE=19, RESULT=3. Then START -> RUN with counters zeroed and the table intact.
- Assert RSTn low mid-RUN, then CFG_WE while in RUN -> all outputs 0 and the table cleared. The write in RUN has no effect: entry reads back as 0 and that checkpoint matches at NUM_INST=0.
